wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to NUM_PORT of NUM_SRC completed instructions per cycle
// (urgent sources first, then round-robin) and drives registered write/commit ports.
module wb_arbiter #(
  parameter int NUM_SRC    = 8,
  parameter int NUM_PORT   = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int CID_W      = 4,
  parameter int STARVE_LIM = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  input  logic [NUM_SRC-1:0]           src_we_i,
  input  logic [NUM_SRC*ADDR_W-1:0]    src_waddr_i,
  input  logic [NUM_SRC*DATA_W-1:0]    src_wdata_i,
  input  logic [NUM_SRC*CID_W-1:0]     src_cid_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  output logic [NUM_PORT-1:0]          port_we_o,
  output logic [NUM_PORT*ADDR_W-1:0]   port_waddr_o,
  output logic [NUM_PORT*DATA_W-1:0]   port_wdata_o,
  output logic [NUM_PORT-1:0]          commit_valid_o,
  output logic [NUM_PORT*CID_W-1:0]    commit_id_o
);

  localparam int CNT_W  = $clog2(STARVE_LIM + 1);
  localparam int PTR_W  = $clog2(NUM_SRC);
  localparam int PCNT_W = $clog2(NUM_PORT + 1);

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]          starve_cnt_q [NUM_SRC];
  logic [CNT_W-1:0]          starve_cnt_d [NUM_SRC];
  logic [NUM_PORT-1:0]       port_we_q, port_we_d;
  logic [NUM_PORT*ADDR_W-1:0] port_waddr_q, port_waddr_d;
  logic [NUM_PORT*DATA_W-1:0] port_wdata_q, port_wdata_d;
  logic [NUM_PORT-1:0]       commit_valid_q, commit_valid_d;
  logic [NUM_PORT*CID_W-1:0] commit_id_q, commit_id_d;

  logic [ADDR_W-1:0]  src_waddr [NUM_SRC];
  logic [NUM_SRC-1:0] urgent;
  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   sel_idx [NUM_PORT];
  logic [PCNT_W-1:0]  sel_cnt;
  logic [PTR_W-1:0]   idx;
  logic [PTR_W:0]     rot_sum;
  logic               cand;
  logic               hazard;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_waddr[i] = src_waddr_i[i*ADDR_W +: ADDR_W];
      urgent[i]    = (starve_cnt_q[i] == CNT_W'(STARVE_LIM));
    end
  end

  // Pass 0 visits urgent sources by index, pass 1 visits the rest rotated from rr_ptr;
  // a candidate is skipped if an earlier grant already writes the same nonzero register.
  always_comb begin
    grant    = '0;
    sel_cnt  = '0;
    rr_ptr_d = rr_ptr_q;
    idx      = '0;
    rot_sum  = '0;
    cand     = 1'b0;
    hazard   = 1'b0;
    for (int k = 0; k < NUM_PORT; k++) sel_idx[k] = '0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (p == 0) begin
          idx = PTR_W'(j);
        end else begin
          rot_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(j);
          if (rot_sum >= (PTR_W+1)'(NUM_SRC)) rot_sum = rot_sum - (PTR_W+1)'(NUM_SRC);
          idx = rot_sum[PTR_W-1:0];
        end
        cand   = src_valid_i[idx] && (urgent[idx] == (p == 0));
        hazard = 1'b0;
        for (int k = 0; k < NUM_PORT; k++) begin
          if (PCNT_W'(k) < sel_cnt && src_we_i[sel_idx[k]] &&
              src_waddr[sel_idx[k]] == src_waddr[idx] && src_waddr[idx] != '0)
            hazard = 1'b1;
        end
        if (cand && !hazard && sel_cnt < PCNT_W'(NUM_PORT)) begin
          grant[idx] = 1'b1;
          for (int k = 0; k < NUM_PORT; k++)
            if (PCNT_W'(k) == sel_cnt) sel_idx[k] = idx;
          sel_cnt = sel_cnt + 1'b1;
          if (p == 1)
            rr_ptr_d = (idx == PTR_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  assign src_ready_o = rst ? '0 : grant;

  always_comb begin
    port_we_d      = '0;
    port_waddr_d   = '0;
    port_wdata_d   = '0;
    commit_valid_d = '0;
    commit_id_d    = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      if (PCNT_W'(k) < sel_cnt) begin
        commit_valid_d[k]              = 1'b1;
        commit_id_d[k*CID_W +: CID_W]  = src_cid_i[int'(sel_idx[k])*CID_W +: CID_W];
        if (src_we_i[sel_idx[k]]) begin
          port_we_d[k]                    = (src_waddr[sel_idx[k]] != '0);
          port_waddr_d[k*ADDR_W +: ADDR_W] = src_waddr[sel_idx[k]];
          port_wdata_d[k*DATA_W +: DATA_W] = src_wdata_i[int'(sel_idx[k])*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!src_valid_i[i] || grant[i]) starve_cnt_d[i] = '0;
      else if (urgent[i])              starve_cnt_d[i] = starve_cnt_q[i];
      else                             starve_cnt_d[i] = starve_cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      port_we_q      <= '0;
      port_waddr_q   <= '0;
      port_wdata_q   <= '0;
      commit_valid_q <= '0;
      commit_id_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) starve_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      port_we_q      <= port_we_d;
      port_waddr_q   <= port_waddr_d;
      port_wdata_q   <= port_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      for (int i = 0; i < NUM_SRC; i++) starve_cnt_q[i] <= starve_cnt_d[i];
    end
  end

  assign port_we_o      = port_we_q;
  assign port_waddr_o   = port_waddr_q;
  assign port_wdata_o   = port_wdata_q;
  assign commit_valid_o = commit_valid_q;
  assign commit_id_o    = commit_id_q;

endmodule
